output_port_allocator: RTL
==========================

Name: output_port_allocator

Overview:
Per-output-port switch allocator for the mesh router. Shares one router output port (N, E, S, W or Local) among the five input ports whose direction analyzers request it. It uses round-robin arbitration and holds a wormhole lock from the head flit to the tail flit. Transfers are gated by a credit counter that tracks free slots in the downstream input buffer. One instance is built per output port; sel_o drives the crossbar mux select for that port.

Parameters:
NUM_REQ, 5, number of requesting input ports (index 0=N, 1=E, 2=S, 3=W, 4=Local)
BUF_DEPTH, 4, downstream buffer depth; initial and maximum credit count
CNT_W, 3, credit counter width; must satisfy 2^CNT_W > BUF_DEPTH

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  synchronous, active-high reset
req_i  input  NUM_REQ  request bit per input port: its direction-analyzer output selects this output port
valid_i  input  NUM_REQ  a flit is present at the head of that input buffer
tail_i  input  NUM_REQ  the head-of-buffer flit on that input is a tail flit (flit bit 16)
credit_inc_i  input  1  downstream freed one buffer slot (single-cycle pulse)
grant_o  output  NUM_REQ  one-hot owner of the output port; all zeros when idle
sel_o  output  3  binary index of the granted input; 0 when idle
xfer_o  output  1  a flit crosses the crossbar this cycle (drives pop of the granted input FIFO)
credit_o  output  CNT_W  current credit count
overflow_o  output  1  sticky error: credit_inc_i received while credits were already BUF_DEPTH

Behaviour:
- Reset (rst_i=1 at a clock edge) sets: state IDLE, grant_o=0, sel_o=0, rr_ptr=0, credit_o=BUF_DEPTH, overflow_o=0. Reset takes priority over all other events, including mid-packet; the packet in flight is abandoned.
- State machine: two states, IDLE and LOCKED.
- IDLE:
  - If (req_i & valid_i) != 0, choose the first index i, searching upward from rr_ptr with wrap at NUM_REQ, that has req_i[i] & valid_i[i].
  - The next edge registers grant_o = one-hot(i), sel_o = i, state = LOCKED.
  - Arbitration does not require credits.
  - xfer_o = 0 in IDLE.
- LOCKED, owner g:
  - xfer_o = valid_i[g] & (credit_o != 0). This is combinational from registered state and inputs; there is no extra latency.
  - The lock is held regardless of req_i. Deassertion of req_i[g] mid-packet is ignored (wormhole).
  - If xfer_o & tail_i[g]: next edge sets state = IDLE, grant_o = 0, sel_o = 0, rr_ptr = (g+1) mod NUM_REQ.
  - Otherwise the state is held.
- Packet timing:
  - There is a minimum of one IDLE cycle between packets on the same port.
  - Head-to-first-transfer latency is 1 cycle (request cycle, then grant cycle with xfer).
  - A single-flit packet (head with tail_i=1) locks for exactly one transfer.
- Credits:
  - Next credit = credit − xfer_o + credit_inc_i.
  - Simultaneous xfer_o and credit_inc_i leaves the count unchanged.
  - At credit 0 there is no xfer; grant is held and the owner stalls.
  - credit_inc_i at BUF_DEPTH with no xfer: the count saturates at BUF_DEPTH and overflow_o is set to 1, which holds until reset.
  - The count never wraps below 0.
- rr_ptr updates only on packet completion. A requester that has just finished becomes lowest priority.
- grant_o, sel_o, credit_o and overflow_o are registered outputs.

Test Plan:
- Reset then idle: req_i=0 for 5 cycles → grant_o=0, sel_o=0, xfer_o=0, credit_o=4, overflow_o=0.
- Single requester, 3-flit packet: req_i=valid_i=5'b00010, tail on the 3rd flit, credit_inc_i=0 → grant_o=5'b00010 and sel_o=1 one cycle later. xfer_o=1 for 3 consecutive cycles, credit_o 4→1, then IDLE with rr_ptr=2.
- Round-robin fairness: inputs 0, 2 and 4 request continuously with 1-flit packets and ample credits → grant order 0, 2, 4, 0, 2, each separated by one idle cycle.
- Credit stall: credit_o reaches 0 mid-packet → xfer_o=0 and grant held. A credit_inc_i pulse → credit 1, xfer_o=1 next cycle. Simultaneous xfer and inc → credit unchanged.
- Wormhole hold and reset: owner 3 drops req_i[3] mid-packet while input 0 requests → grant stays 5'b01000. Asserting rst_i mid-packet → next cycle grant_o=0, credit_o=4, rr_ptr=0.
- Overflow: credit_inc_i pulsed at credit_o=4 → credit_o stays 4, overflow_o=1 and remains 1 until rst_i.

Source files
------------

// File: rtl/output_port_allocator.sv
// -----------------------------------------------------------------------------
// output_port_allocator
//
// Switch allocator for one mesh-router output port. Up to NUM_REQ input ports
// compete for the port; a round-robin arbiter picks the next owner, and the
// owner keeps the port (wormhole lock) from its head flit until its tail flit
// has crossed. Each transfer uses one credit, which stands for one free slot
// in the downstream input buffer. Credits come back through credit_inc_i.
//
// Ports:
//   clk_i        - clock; all state changes on the rising edge
//   rst_i        - synchronous, active-high reset
//   req_i        - per-input request: its route selects this output port
//   valid_i      - per-input: a flit is at the head of that input buffer
//   tail_i       - per-input: the head flit of that input is a tail flit
//   credit_inc_i - downstream released one buffer slot (one-cycle pulse)
//   grant_o      - one-hot owner of the port; zero when idle (registered)
//   sel_o        - binary index of the owner, drives the crossbar select;
//                  zero when idle (registered)
//   xfer_o       - a flit crosses this cycle; pops the owner's input FIFO
//   credit_o     - current credit count (registered)
//   overflow_o   - sticky: a credit was returned while already full
// -----------------------------------------------------------------------------
module output_port_allocator #(
    parameter int NUM_REQ   = 5,
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [NUM_REQ-1:0] tail_i,
    input  logic               credit_inc_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [2:0]         sel_o,
    output logic               xfer_o,
    output logic [CNT_W-1:0]   credit_o,
    output logic               overflow_o
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(BUF_DEPTH);
    localparam logic [2:0]       LAST_IDX   = 3'(NUM_REQ - 1);

    state_t             state;
    logic [2:0]         rr_ptr;

    logic [NUM_REQ-1:0] cand;
    logic               pick_found;
    logic [2:0]         pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;

    logic               owner_valid;
    logic               owner_tail;
    logic               credit_nz;
    logic               pkt_done;
    logic [2:0]         rr_next;

    assign cand = req_i & valid_i;

    // Round-robin search: scan upward from rr_ptr and wrap at NUM_REQ; the
    // first candidate found wins.
    always_comb begin
        int unsigned idx;
        pick_found  = 1'b0;
        pick_idx    = '0;
        pick_onehot = '0;
        idx         = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!pick_found && cand[3'(idx)]) begin
                pick_found = 1'b1;
                pick_idx   = 3'(idx);
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (pick_found && (pick_idx == 3'(j))) begin
                pick_onehot[j] = 1'b1;
            end
        end
    end

    // sel_o holds the owner index while LOCKED, so it also selects the
    // owner's valid and tail bits.
    assign owner_valid = valid_i[sel_o];
    assign owner_tail  = tail_i[sel_o];
    assign credit_nz   = (credit_o != '0);

    assign xfer_o   = (state == LOCKED) && owner_valid && credit_nz;
    assign pkt_done = xfer_o && owner_tail;

    // The owner that just finished gets the lowest priority next time.
    assign rr_next = (sel_o == LAST_IDX) ? 3'd0 : sel_o + 3'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            grant_o    <= '0;
            sel_o      <= '0;
            rr_ptr     <= '0;
            credit_o   <= CREDIT_MAX;
            overflow_o <= 1'b0;
        end else begin
            // Arbitration and wormhole lock
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state   <= LOCKED;
                        grant_o <= pick_onehot;
                        sel_o   <= pick_idx;
                    end
                end
                LOCKED: begin
                    if (pkt_done) begin
                        state   <= IDLE;
                        grant_o <= '0;
                        sel_o   <= '0;
                        rr_ptr  <= rr_next;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= '0;
                    sel_o   <= '0;
                end
            endcase

            // Credit accounting. A transfer together with a returned credit
            // leaves the count as it is. A transfer needs credit_o != 0, so
            // the count cannot go below zero.
            if (xfer_o && !credit_inc_i) begin
                credit_o <= credit_o - CNT_W'(1);
            end else if (!xfer_o && credit_inc_i) begin
                if (credit_o == CREDIT_MAX) begin
                    overflow_o <= 1'b1;
                end else begin
                    credit_o <= credit_o + CNT_W'(1);
                end
            end
        end
    end

endmodule
